input_sequencer: RTL and testbench
==================================

Name: input_sequencer

Overview:
- Front-end stage directly upstream of the processor's output/display logic.
- Conditions the raw step pushbutton and the peek switch: 2-flop synchronise, then debounce.
- Generates a single-cycle STEP pulse for the controller and the datapath.
- Owns the 2-bit timestep counter TIME and the registered DONE flag consumed by the display stage; PEEKb is delivered as a clean level.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a key level change is accepted (5 ms at 50 MHz)
CNT_W, 18, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES

Ports:
CLK  input  1  system clock, all state on rising edge
RSTb  input  1  asynchronous active-low reset
KEY_STEPb  input  1  raw step pushbutton, active-low (0 = pressed), asynchronous to CLK
SW_PEEK  input  1  raw peek slide switch, asynchronous to CLK
DONE_REQ  input  1  from controller: current timestep completes the instruction; sampled only when STEP=1
STEP  output  1  one-cycle pulse per accepted button press
TIME  output  2  current timestep 0..3
DONE  output  1  instruction-complete flag, active-high; display stage inverts it for the LED
PEEKb  output  1  debounced SW_PEEK level; 1 = display shows BUS, 0 = display shows REG

Behaviour:
- Reset (RSTb=0, asynchronous, effective immediately):
  - STEP=0, TIME=0, DONE=0, PEEKb=1.
  - Synchroniser flops: KEY path reset to 1, SW path reset to 1.
  - Debounce counters reset to 0; debounced levels reset to 1.
- Reset release: state leaves reset on the first CLK edge after RSTb rises. No spurious STEP is allowed even if the key is held at release; it is accepted only after a full debounce interval.
- Synchronise: two flops per raw input. Raw inputs are never used before the second flop.
- Debounce (per input, identical logic):
  - Holds a stable level and a counter.
  - Synced input equals stable level: counter <= 0.
  - Synced input differs: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while still differing: stable level <= synced input, counter <= 0.
  - Any return to the stable level before that point clears the counter (bounce rejection).
- STEP:
  - Asserted for exactly one cycle, the cycle after the debounced KEY_STEPb level goes 1->0.
  - Release (0->1) produces no pulse. Holding the button produces no repeats.
  - Latency from a clean press: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle.
- TIME, updated only on cycles with STEP=1:
  - DONE_REQ=1: TIME <= 0.
  - Else TIME=3: TIME <= 0 (wrap).
  - Else TIME <= TIME+1.
  - Without STEP, TIME holds.
- DONE, updated only with STEP=1:
  - Registered as DONE <= DONE_REQ on the same edge that updates TIME.
  - Therefore DONE=1 exactly while TIME=0 following a completing step.
  - Cleared on the next STEP unless DONE_REQ is reasserted.
- Simultaneous events:
  - DONE_REQ=1 with TIME=3: TIME=0, DONE=1 (DONE_REQ takes priority over plain wrap).
  - DONE_REQ with STEP=0: ignored.
- PEEKb: equals the debounced SW_PEEK level. Independent of STEP and TIME.
- Reset mid-debounce or mid-instruction: all state returns to reset values. A press in flight is discarded.
- Arithmetic: TIME increment is modulo 4 in 2 bits. The counter compare uses CNT_W-bit unsigned values; no overflow is possible given the parameter constraint.

Decomposition:
- Package proc_pkg:
  - typedef timestep_t (logic [1:0]).
  - Constants T0..T3 = 2'd0..2'd3.
  - Constant DEBOUNCE_DEFAULT = 250000.
- Sub-module key_debouncer:
  - Parameters DEBOUNCE_CYCLES, CNT_W.
  - Ports CLK, RSTb, RAW, LEVEL.
  - Contains the 2-flop synchroniser and the debounce counter.
  - Instantiated twice: step key and peek switch.
- input_sequencer contains:
  - The press-edge detector.
  - The TIME/DONE register logic.

Test Plan:
Bench sets DEBOUNCE_CYCLES=4 and CNT_W=3.
1. Reset with KEY_STEPb=0 held, release RSTb -> STEP=0, TIME=0, DONE=0, PEEKb=1 during reset; exactly one STEP pulse after 2+4+1 cycles, none thereafter while held.
2. KEY_STEPb toggles 1-0-1-0 every 2 cycles, then stays 0 -> no STEP during toggling; single STEP 7 cycles after the final stable 0; release gives no pulse.
3. Four clean presses, DONE_REQ=0 -> TIME sequence 1,2,3,0; DONE stays 0; each STEP exactly one cycle wide.
4. Presses taking TIME to 2, then a press with DONE_REQ=1 -> TIME=0, DONE=1; next press with DONE_REQ=0 -> TIME=1, DONE=0.
5. TIME=3, press with DONE_REQ=1; additionally pulse DONE_REQ=1 on non-STEP cycles -> TIME=0, DONE=1 from the STEP press; off-STEP DONE_REQ pulses cause no change.
6. SW_PEEK 1->0 with a 2-cycle glitch back to 1, then stable 0; RSTb pulsed low mid-count on a second trial -> PEEKb=0 only after 4 stable cycles; reset forces PEEKb=1, TIME=0, DONE=0 immediately.

Source files
------------

// File: rtl/input_sequencer_pkg.sv
// rtl/input_sequencer_pkg.sv - shared types and constants for the input sequencer
//
// Purpose: timestep type, timestep constants, default debounce length and the
//          TIME advance rule used by the sequencer.
// Ports:   none (package).
package proc_pkg;

  typedef logic [1:0] timestep_t;

  localparam timestep_t T0 = 2'd0;
  localparam timestep_t T1 = 2'd1;
  localparam timestep_t T2 = 2'd2;
  localparam timestep_t T3 = 2'd3;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 250000;

  // A completing step always returns to T0, which is why it wins over the
  // plain T3 -> T0 wrap; otherwise advance modulo 4.
  function automatic timestep_t next_timestep(input timestep_t t, input logic done_req);
    timestep_t n;
    if (done_req) begin
      n = T0;
    end else if (t == T3) begin
      n = T0;
    end else begin
      n = t + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/input_sequencer_if.sv
// rtl/input_sequencer_if.sv - signal bundle between the sequencer, controller and display
//
// Purpose: groups the raw inputs, the controller request and the sequencer outputs.
// Signals: KEY_STEPb (raw step key, active-low), SW_PEEK (raw peek switch),
//          DONE_REQ (controller completes instruction), STEP (one-cycle pulse),
//          TIME (timestep 0..3), DONE (instruction complete), PEEKb (clean peek level).
// Modports: master drives the raw inputs and DONE_REQ; slave is the sequencer.
interface input_sequencer_if;
  import proc_pkg::*;

  logic      KEY_STEPb;
  logic      SW_PEEK;
  logic      DONE_REQ;
  logic      STEP;
  timestep_t TIME;
  logic      DONE;
  logic      PEEKb;

  modport master (
    output KEY_STEPb,
    output SW_PEEK,
    output DONE_REQ,
    input  STEP,
    input  TIME,
    input  DONE,
    input  PEEKb
  );

  modport slave (
    input  KEY_STEPb,
    input  SW_PEEK,
    input  DONE_REQ,
    output STEP,
    output TIME,
    output DONE,
    output PEEKb
  );

endinterface

// File: rtl/input_sequencer_key_debouncer.sv
// rtl/input_sequencer_key_debouncer.sv - two-flop synchroniser plus stable-count debouncer
//
// Purpose: brings an asynchronous key/switch into the CLK domain and only
//          accepts a level change after DEBOUNCE_CYCLES consecutive differing cycles.
// Ports:   CLK   - system clock
//          RSTb  - asynchronous active-low reset
//          RAW   - raw asynchronous input (idle level 1)
//          LEVEL - debounced level, resets to 1
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic RAW,
  output logic LEVEL
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // RAW only ever feeds r_sync1; everything downstream uses r_sync2.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RAW;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the stable level clears the count, so a bounce restarts
  // the whole interval rather than pausing it.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + LP_ONE;
    end
  end

  assign LEVEL = r_level;

endmodule

// File: rtl/input_sequencer.sv
// rtl/input_sequencer.sv - step/peek conditioning, STEP pulse and TIME/DONE registers
//
// Purpose: debounces the step key and peek switch, emits one STEP pulse per
//          accepted press and keeps the timestep counter and DONE flag.
// Ports:   CLK  - system clock
//          RSTb - asynchronous active-low reset
//          bus  - input_sequencer_if.slave (KEY_STEPb, SW_PEEK, DONE_REQ in;
//                 STEP, TIME, DONE, PEEKb out)
module input_sequencer
  import proc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic                CLK,
  input  logic                RSTb,
  input_sequencer_if.slave    bus
);

  logic      w_key_level;
  logic      w_peek_level;
  logic      r_key_level_d;
  logic      r_step;
  timestep_t r_time;
  logic      r_done;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_step_db (
    .CLK   (CLK),
    .RSTb  (RSTb),
    .RAW   (bus.KEY_STEPb),
    .LEVEL (w_key_level)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_peek_db (
    .CLK   (CLK),
    .RSTb  (RSTb),
    .RAW   (bus.SW_PEEK),
    .LEVEL (w_peek_level)
  );

  // Press edge: debounced level falling 1 -> 0. The delayed copy resets to 1
  // to match the debouncer, so no pulse can appear at reset release.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_key_level_d <= 1'b1;
      r_step        <= 1'b0;
    end else begin
      r_key_level_d <= w_key_level;
      r_step        <= r_key_level_d & ~w_key_level;
    end
  end

  // TIME and DONE move together, only on STEP cycles; DONE_REQ is ignored otherwise.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_time <= T0;
      r_done <= 1'b0;
    end else if (r_step) begin
      r_time <= next_timestep(r_time, bus.DONE_REQ);
      r_done <= bus.DONE_REQ;
    end
  end

  assign bus.STEP  = r_step;
  assign bus.TIME  = r_time;
  assign bus.DONE  = r_done;
  assign bus.PEEKb = w_peek_level;

endmodule

// File: tb/tb_input_sequencer.sv
// tb/tb_input_sequencer.sv - self-checking bench for input_sequencer
module tb_input_sequencer;
  import proc_pkg::*;

  typedef struct packed {
    logic [1:0] t;
    logic       d;
  } exp_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  exp_t      q[$];
  timestep_t m_time;
  logic      m_done;

  always #5 clk = ~clk;

  input_sequencer_if bus();

  input_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLK  (clk),
    .RSTb (rstb),
    .bus  (bus)
  );

  task automatic do_press(input logic dreq, input string tag);
    exp_t e;
    int   lat;
    int   extra;
    if (dreq) begin
      m_time = T0;
      m_done = 1'b1;
    end else begin
      m_time = (m_time == T3) ? T0 : m_time + 2'd1;
      m_done = 1'b0;
    end
    e.t = m_time;
    e.d = m_done;
    q.push_back(e);
    bus.KEY_STEPb = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.STEP === 1'b1) lat = k;
    end
    checks++;
    if (lat != 7) begin
      failures++;
      $display("FAIL %s step_latency actual=%0d required=7", tag, lat);
    end
    bus.DONE_REQ = dreq;
    @(negedge clk);
    bus.DONE_REQ = 1'b0;
    e = q.pop_front();
    checks++;
    if (bus.STEP !== 1'b0) begin
      failures++;
      $display("FAIL %s step_width actual=%b required=0", tag, bus.STEP);
    end
    checks++;
    if (bus.TIME !== e.t || bus.DONE !== e.d) begin
      failures++;
      $display("FAIL %s time_done actual=%0d/%b required=%0d/%b", tag, bus.TIME, bus.DONE, e.t, e.d);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.STEP !== 1'b0) extra++;
    end
    bus.KEY_STEPb = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.STEP !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL %s hold_release_pulses actual=%0d required=0", tag, extra);
    end
    checks++;
    if (bus.TIME !== e.t || bus.DONE !== e.d) begin
      failures++;
      $display("FAIL %s time_done_hold actual=%0d/%b required=%0d/%b", tag, bus.TIME, bus.DONE, e.t, e.d);
    end
  endtask

  task automatic apply_reset(input string tag);
    rstb = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.STEP !== 1'b0 || bus.TIME !== T0 || bus.DONE !== 1'b0 || bus.PEEKb !== 1'b1) begin
      failures++;
      $display("FAIL %s reset_state actual=%b/%0d/%b/%b required=0/0/0/1", tag, bus.STEP, bus.TIME, bus.DONE, bus.PEEKb);
    end
    @(negedge clk);
    rstb   = 1'b1;
    m_time = T0;
    m_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.KEY_STEPb = 1'b0;
    bus.SW_PEEK   = 1'b1;
    bus.DONE_REQ  = 1'b0;
    rstb          = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.STEP !== 1'b0 || bus.TIME !== T0 || bus.DONE !== 1'b0 || bus.PEEKb !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold actual=%b/%0d/%b/%b required=0/0/0/1", bus.STEP, bus.TIME, bus.DONE, bus.PEEKb);
    end
    rstb   = 1'b1;
    m_time = T0;
    m_done = 1'b0;
    do_press(1'b0, "reset_release");
  endtask

  task automatic test_bounce();
    int spurious = 0;
    for (int i = 0; i < 4; i++) begin
      bus.KEY_STEPb = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (bus.STEP !== 1'b0) spurious++;
      end
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL bounce_pulses actual=%0d required=0", spurious);
    end
    do_press(1'b0, "bounce_final");
  endtask

  task automatic test_count();
    apply_reset("count");
    for (int i = 0; i < 4; i++) do_press(1'b0, "count");
  endtask

  task automatic test_done();
    apply_reset("done");
    do_press(1'b0, "done_pre");
    do_press(1'b0, "done_pre");
    do_press(1'b1, "done_req");
    do_press(1'b0, "done_clear");
  endtask

  task automatic test_done_priority();
    apply_reset("prio");
    for (int i = 0; i < 3; i++) do_press(1'b0, "prio_pre");
    for (int i = 0; i < 3; i++) begin
      bus.DONE_REQ = 1'b1;
      @(negedge clk);
      bus.DONE_REQ = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.TIME !== m_time || bus.DONE !== m_done) begin
        failures++;
        $display("FAIL offstep_req_a actual=%0d/%b required=%0d/%b", bus.TIME, bus.DONE, m_time, m_done);
      end
    end
    do_press(1'b1, "prio_wrap_done");
    for (int i = 0; i < 3; i++) begin
      bus.DONE_REQ = 1'b1;
      @(negedge clk);
      bus.DONE_REQ = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.TIME !== m_time || bus.DONE !== m_done) begin
        failures++;
        $display("FAIL offstep_req_b actual=%0d/%b required=%0d/%b", bus.TIME, bus.DONE, m_time, m_done);
      end
    end
  endtask

  task automatic test_peek();
    int early = 0;
    int lat   = -1;
    int bad   = 0;
    bus.SW_PEEK = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.PEEKb !== 1'b1) early++;
    end
    bus.SW_PEEK = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.PEEKb !== 1'b1) early++;
    end
    bus.SW_PEEK = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.PEEKb === 1'b0) lat = k;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL peek_glitch_accepted actual=%0d required=0", early);
    end
    checks++;
    if (lat != 6) begin
      failures++;
      $display("FAIL peek_latency actual=%0d required=6", lat);
    end
    // Second trial: peek and key changes in flight when reset hits.
    bus.SW_PEEK   = 1'b1;
    bus.KEY_STEPb = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.PEEKb !== 1'b0) begin
      failures++;
      $display("FAIL peek_midcount actual=%b required=0", bus.PEEKb);
    end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (bus.PEEKb !== 1'b1 || bus.TIME !== T0 || bus.DONE !== 1'b0 || bus.STEP !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual=%b/%0d/%b/%b required=1/0/0/0", bus.PEEKb, bus.TIME, bus.DONE, bus.STEP);
    end
    @(negedge clk);
    bus.KEY_STEPb = 1'b1;
    rstb          = 1'b1;
    m_time        = T0;
    m_done        = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.STEP !== 1'b0 || bus.PEEKb !== 1'b1 || bus.TIME !== T0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL discarded_inflight actual=%0d required=0", bad);
    end
  endtask

  initial begin
    bus.KEY_STEPb = 1'b1;
    bus.SW_PEEK   = 1'b1;
    bus.DONE_REQ  = 1'b0;
    m_time        = T0;
    m_done        = 1'b0;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_count();
    test_done();
    test_done_priority();
    test_peek();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
